// File: rtl/serial_score_adder_pkg.sv
// serial_score_adder_pkg: shared state encodings and default widths for the score path
package serial_score_adder_pkg;

    localparam int SCORE_W = 16;
    localparam int PTS_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADD    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/serial_score_adder_adder_1bit.sv
// adder_1bit: single full-adder cell
module adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_score_adder.sv
// serial_score_adder: bit-serial score accumulator, one bit per clock through one full adder.
// SCORE_SATURATE_EN defined: saturate score to all ones on carry-out; otherwise wrap.
module serial_score_adder #(
    parameter int WIDTH = serial_score_adder_pkg::SCORE_W,
    parameter int PTS_W = serial_score_adder_pkg::PTS_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             start,
    input  logic [PTS_W-1:0] points,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] score,
    output logic             overflow
);
    import serial_score_adder_pkg::*;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic            c;
    logic [CW-1:0]   cnt;
    logic            s;
    logic            co;

    adder_1bit u_fa (
        .a    (a[0]),
        .b    (b[0]),
        .cin  (c),
        .sum  (s),
        .cout (co)
    );

    always_ff @(posedge clk) begin
        done <= 1'b0;
        if (rst || clr) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            score    <= '0;
            overflow <= 1'b0;
            if (rst) begin
                a   <= '0;
                b   <= '0;
                c   <= 1'b0;
                cnt <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: if (start) begin
                    a     <= score;
                    b     <= WIDTH'(points);
                    c     <= 1'b0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= ST_ADD;
                end
                ST_ADD: begin
                    // after WIDTH shifts A holds the full sum, LSB first inserted at MSB
                    a     <= {s, a[WIDTH-1:1]};
                    b     <= {1'b0, b[WIDTH-1:1]};
                    c     <= co;
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == LAST) ? ST_COMMIT : ST_ADD;
                end
                ST_COMMIT: begin
`ifdef SCORE_SATURATE_EN
                    score <= c ? '1 : a;
`else
                    score <= a;
`endif
                    overflow <= overflow | c;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_score_adder.md
# serial_score_adder

Bit-serial score accumulator for the game's scoring path. Each accepted hit adds a `points` value to a running `score` register, one bit per clock. The bit arithmetic runs through a single full-adder cell plus a registered carry. The block sits between the hit-judgement logic, which issues `start` and `points`, and the score display/BCD path, which consumes `score` and `done`.

## Interface
- `WIDTH`, default 16: score register width in bits (≥ 2).
- `PTS_W`, default 8: points operand width (≤ `WIDTH`); zero-extended to `WIDTH`.

Ports:
- `clk` input, 1: single system clock, rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `clr` input, 1: synchronous score clear, active-high.
- `start` input, 1: request to add `points`; sampled only in IDLE.
- `points` input, `PTS_W`: addend, captured on an accepted `start`.
- `busy` output, 1: addition in progress.
- `done` output, 1: one-cycle pulse; the new `score` is valid in that cycle.
- `score` output, `WIDTH`: committed score.
- `overflow` output, 1: sticky flag, set when any addition carries out of the MSB.

## Operation
- States: IDLE, ADD, COMMIT.
- **IDLE**, `start`=1 and `clr`=0:
  - Load operand shift register A with `score`.
  - Load operand shift register B with zero-extended `points`.
  - Set carry to 0 and bit counter to 0. Go to ADD.
- **ADD**, one bit per cycle:
  - s = A[0]^B[0]^c; c_next = majority(A[0],B[0],c).
  - Shift A right with s inserted at the MSB. Shift B right. Register the carry. Increment the counter.
  - When counter = `WIDTH`-1 after this bit, go to COMMIT.
- **COMMIT**:
  - If the final carry is 1, set `overflow`.
  - Write `score`: A (wrapped sum) or saturated value, per Configuration.
  - Pulse `done`. Go to IDLE.
- `score` holds its old value throughout ADD. It changes only at the COMMIT edge, or on `clr`/`rst`.
- `start` while `busy`=1 is ignored and not queued.
- `clr` in any state:
  - `score`=0, `overflow`=0, go to IDLE, `busy`=0.
  - An in-flight addition is aborted with no `done`.
- `start` and `clr` in the same cycle: `clr` wins and `start` is dropped.
- `points`=0 is still a full `WIDTH`+1 cycle transaction that pulses `done`.
- `rst` gives the same result as `clr`, and additionally clears the counter, carry, A and B.

## Timing
- Reset values: `busy`=0, `done`=0, `score`=0, `overflow`=0, state IDLE.
- `start` sampled at edge E0: `busy`=1 from E0.
- Edges E1…E`WIDTH` process bits 0…`WIDTH`-1.
- At edge E(`WIDTH`+1): `score` is updated, `done`=1 for exactly one cycle, and `busy`=0.
- Latency from `start` sample to new `score` is `WIDTH`+1 clocks. `busy` stays high for `WIDTH`+1 cycles.
- Back-to-back: `start` may be asserted in the `done` cycle and is accepted, because state is IDLE. Throughput is one add per `WIDTH`+1 clocks.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration
- `SCORE_SATURATE_EN` defined: on final carry=1, `score` becomes all ones (2^`WIDTH`-1). Further adds keep it there and `overflow`=1.
- Not defined: `score` wraps modulo 2^`WIDTH` and `overflow`=1.
- In both cases, `overflow` is cleared only by `rst`/`clr`.

## Structure
- Shared include/package holds:
  - State encodings `ST_IDLE`, `ST_ADD`, `ST_COMMIT` (2-bit).
  - Default widths `SCORE_W`=16 and `PTS_W`=8 for reuse by the display path.
- One sub-module: the team's `adder_1bit` full-adder cell, instantiated once. It is fed A[0], B[0] and the carry register, and supplies sum and carry-out.
- Counter width is clog2(`WIDTH`) bits.

## Test plan
- **Reset:** assert `rst` 2 cycles → `score`=0x0000, `busy`=0, `done`=0, `overflow`=0.
- **Single add:** `start` with `points`=0x2A from `score`=0 → `busy` high for 17 cycles, `done` pulses once, `score`=0x002A.
- **Carry propagation:** reach `score`=0x00FF, then add 0x01 → `score`=0x0100, `overflow`=0. Then add 0x00 → `score` unchanged and `done` still pulses.
- **Overflow** (`WIDTH`=8, `PTS_W`=8), `score`=0xF0 plus 0x20:
  - Macro undefined → `score`=0x10, `overflow`=1.
  - Macro defined → `score`=0xFF, `overflow`=1, and a later add of 0x01 keeps 0xFF.
- **Ignored start and abort:**
  - `start` pulsed mid-ADD → ignored, and exactly one `done` follows.
  - `clr` at bit 5 of an add → `score`=0, `busy`=0, and no `done` ever follows.
- **Simultaneous start and clear:** `start`+`clr` in IDLE with `score`=0x0030 → `score`=0, `busy` stays 0, no `done`.
